// File: rtl/burst_clock_gen.sv
// Burst/continuous divided-clock generator with busy/done status and period count.
// Optional edge strobes are enabled by defining BURST_CLOCK_GEN_EDGE_STROBE_EN.
module burst_clock_gen #(
  parameter int CNT_W   = 32,
  parameter int DIV_MIN = 1
) (
  input  logic             I_CLK,
  input  logic             I_RSTn,
  input  logic             I_START,
  input  logic             I_ABORT,
  input  logic             I_CONT,
  input  logic             I_CPOL,
  input  logic [CNT_W-1:0] I_DIV_FACTOR,
  input  logic [CNT_W-1:0] I_ACTIVE_COUNT,
  output logic             O_CLK_DIV,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic [CNT_W-1:0] O_PERIOD_CNT
`ifdef BURST_CLOCK_GEN_EDGE_STROBE_EN
  ,
  output logic             O_LEAD_STB,
  output logic             O_TRAIL_STB
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACT    = 2'd1;
  localparam logic [1:0] S_IDL_PH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_MIN_C = CNT_W'(DIV_MIN);

  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] phase_r, phase_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] dm1_r;
  logic [CNT_W-1:0] count_r;
  logic             cont_r;
  logic             cpol_r;
  logic             start_q_r;
  logic             armed_r;
  logic             load_s;
  logic             start_edge_s;
  logic [CNT_W-1:0] div_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             clk_s, busy_s, done_s;

  // armed_r keeps a start level held across reset release from looking like an edge
  assign start_edge_s = I_START & ~start_q_r & armed_r;
  assign div_s        = (I_DIV_FACTOR < DIV_MIN_C) ? DIV_MIN_C : I_DIV_FACTOR;
  assign cnt_inc_s    = cnt_r + ONE_C;

  // Next-state, phase counter and period counter
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    if (I_ABORT) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_edge_s) begin
            load_s = 1'b1;
            cnt_s  = ZERO_C;
            if (!I_CONT && (I_ACTIVE_COUNT == ZERO_C)) begin
              state_s = S_DONE;
            end else begin
              state_s = S_ACT;
              phase_s = div_s - ONE_C;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_ACT: begin
          if (phase_r == ZERO_C) begin
            state_s = S_IDL_PH;
            phase_s = dm1_r;
          end else begin
            phase_s = phase_r - ONE_C;
          end
        end
        S_IDL_PH: begin
          if (phase_r == ZERO_C) begin
            cnt_s   = cnt_inc_s;
            phase_s = dm1_r;
            // a period is only ever ended here, so no runt pulses are possible
            if (cont_r) begin
              state_s = I_START ? S_ACT : S_DONE;
            end else begin
              state_s = (cnt_inc_s == count_r) ? S_DONE : S_ACT;
            end
          end else begin
            phase_s = phase_r - ONE_C;
          end
        end
        S_DONE: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // Output decode; outputs follow the state one cycle later, abort acts at once
  always_comb begin
    clk_s  = I_CPOL;
    busy_s = 1'b0;
    done_s = 1'b0;
    if (I_ABORT) begin
      clk_s = I_CPOL;
    end else begin
      case (state_r)
        S_IDLE:   clk_s = I_CPOL;
        S_ACT: begin
          clk_s  = ~cpol_r;
          busy_s = 1'b1;
        end
        S_IDL_PH: begin
          clk_s  = cpol_r;
          busy_s = 1'b1;
        end
        S_DONE: begin
          clk_s  = cpol_r;
          done_s = 1'b1;
        end
        default:  clk_s = I_CPOL;
      endcase
    end
  end

  // State, counters and start-edge detector
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_r   <= S_IDLE;
      phase_r   <= ZERO_C;
      cnt_r     <= ZERO_C;
      start_q_r <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      phase_r   <= phase_s;
      cnt_r     <= cnt_s;
      start_q_r <= I_START;
      armed_r   <= armed_r | ~I_START;
    end
  end

  // Configuration captured only on an accepted start edge
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      dm1_r   <= ZERO_C;
      count_r <= ZERO_C;
      cont_r  <= 1'b0;
      cpol_r  <= 1'b0;
    end else if (load_s) begin
      dm1_r   <= div_s - ONE_C;
      count_r <= I_ACTIVE_COUNT;
      cont_r  <= I_CONT;
      cpol_r  <= I_CPOL;
    end
  end

  // Registered outputs
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      O_CLK_DIV    <= 1'b0;
      O_BUSY       <= 1'b0;
      O_DONE       <= 1'b0;
      O_PERIOD_CNT <= ZERO_C;
    end else begin
      O_CLK_DIV    <= clk_s;
      O_BUSY       <= busy_s;
      O_DONE       <= done_s;
      O_PERIOD_CNT <= cnt_r;
    end
  end

`ifdef BURST_CLOCK_GEN_EDGE_STROBE_EN
  logic lead_s, trail_s;

  // Phase reload value marks the first cycle of each half-period
  always_comb begin
    lead_s  = 1'b0;
    trail_s = 1'b0;
    if (!I_ABORT) begin
      lead_s  = (state_r == S_ACT)    && (phase_r == dm1_r);
      trail_s = (state_r == S_IDL_PH) && (phase_r == dm1_r);
    end else begin
      lead_s  = 1'b0;
      trail_s = 1'b0;
    end
  end

  // Strobe registers share O_CLK_DIV timing
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      O_LEAD_STB  <= 1'b0;
      O_TRAIL_STB <= 1'b0;
    end else begin
      O_LEAD_STB  <= lead_s;
      O_TRAIL_STB <= trail_s;
    end
  end
`endif

endmodule
